// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level round sequencer.
// Filters the mode switches over frame ticks and latches the chosen mode.
// Runs MENU -> COUNTDOWN (3,2,1) -> PLAY -> OVER -> MENU and drives the
// one-hot screen selects. Every output is registered.
module game_flow_ctrl #(
    parameter int unsigned SETTLE_FRAMES    = 8,
    parameter int unsigned COUNTDOWN_FRAMES = 60,
    parameter int unsigned END_FRAMES       = 180
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       btn_start,
    input  logic       frame_tick,
    input  logic       game_over,
    output logic       screen_idle,
    output logic       screen_single,
    output logic       screen_multi,
    output logic       game_run,
    output logic [1:0] countdown,
    output logic       round_start
);

    localparam int unsigned SW_W  = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned F_MAX = (COUNTDOWN_FRAMES > END_FRAMES) ? COUNTDOWN_FRAMES : END_FRAMES;
    localparam int unsigned FC_W  = $clog2(F_MAX + 1);

    localparam logic [SW_W-1:0] SETTLE_LAST = SW_W'(SETTLE_FRAMES);
    localparam logic [FC_W-1:0] CD_LAST     = FC_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [FC_W-1:0] END_LAST    = FC_W'(END_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_MENU,
        ST_COUNTDOWN,
        ST_PLAY,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_SINGLE,
        MODE_MULTI
    } mode_t;

    // Switch filter
    logic [1:0]      r_sw_cand;
    logic [1:0]      r_sw_stable;
    logic [SW_W-1:0] r_settle_cnt;
    logic [SW_W-1:0] w_settle_inc;

    // Start button edge detect
    logic            r_btn_d;
    logic            w_start_edge;

    // Sequencer
    state_t          r_state,     w_state_next;
    mode_t           r_mode_q,    w_mode_q_next;
    logic [1:0]      r_digit,     w_digit_next;
    logic [FC_W-1:0] r_frame_cnt, w_frame_cnt_next;
    logic            r_play_entry, w_play_entry_next;

    mode_t           w_mode;
    mode_t           w_screen_mode;
    logic            w_abort;

    // Settle counter value after this cycle's tick; saturates at SETTLE_FRAMES
    always_comb begin
        w_settle_inc = r_settle_cnt;
        if (frame_tick && (r_settle_cnt != SETTLE_LAST)) begin
            w_settle_inc = r_settle_cnt + SW_W'(1);
        end
    end

    // Stable value is taken on the settling tick itself, so acceptance is not
    // delayed by an extra cycle behind the counter
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_sw_cand    <= '0;
            r_sw_stable  <= '0;
            r_settle_cnt <= '0;
        end else if (sw != r_sw_cand) begin
            r_sw_cand    <= sw;
            r_settle_cnt <= '0;
        end else begin
            r_settle_cnt <= w_settle_inc;
            if (w_settle_inc == SETTLE_LAST) begin
                r_sw_stable <= r_sw_cand;
            end
        end
    end

    // Decode the filtered switches into a mode
    always_comb begin
        w_mode = MODE_IDLE;
        case (r_sw_stable)
            2'b01:   w_mode = MODE_SINGLE;
            2'b10:   w_mode = MODE_MULTI;
            default: w_mode = MODE_IDLE;
        endcase
    end

    // Delayed button level for rising-edge detection
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_btn_d <= 1'b0;
        end else begin
            r_btn_d <= btn_start;
        end
    end

    assign w_start_edge = btn_start & ~r_btn_d;
    assign w_abort      = (w_mode != r_mode_q);

    // Sequencer state register
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_state      <= ST_MENU;
            r_mode_q     <= MODE_IDLE;
            r_digit      <= '0;
            r_frame_cnt  <= '0;
            r_play_entry <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mode_q     <= w_mode_q_next;
            r_digit      <= w_digit_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_play_entry <= w_play_entry_next;
        end
    end

    // Sequencer next state; a mode mismatch outside MENU overrides everything
    always_comb begin
        w_state_next      = r_state;
        w_mode_q_next     = r_mode_q;
        w_digit_next      = r_digit;
        w_frame_cnt_next  = r_frame_cnt;
        w_play_entry_next = 1'b0;
        case (r_state)
            ST_MENU: begin
                if (w_start_edge && (w_mode != MODE_IDLE)) begin
                    w_state_next     = ST_COUNTDOWN;
                    w_mode_q_next    = w_mode;
                    w_digit_next     = 2'd3;
                    w_frame_cnt_next = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (w_abort) begin
                    w_state_next = ST_MENU;
                end else if (frame_tick) begin
                    if (r_frame_cnt == CD_LAST) begin
                        w_frame_cnt_next = '0;
                        w_digit_next     = r_digit - 2'd1;
                        if (r_digit == 2'd1) begin
                            w_state_next      = ST_PLAY;
                            w_play_entry_next = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + FC_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (w_abort) begin
                    w_state_next = ST_MENU;
                end else if (game_over) begin
                    w_state_next     = ST_OVER;
                    w_frame_cnt_next = '0;
                end
            end
            ST_OVER: begin
                if (w_abort) begin
                    w_state_next = ST_MENU;
                end else if (frame_tick) begin
                    if (r_frame_cnt == END_LAST) begin
                        w_state_next = ST_MENU;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + FC_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_MENU;
            end
        endcase
    end

    // Mode shown on screen: live decode in MENU, latched mode during a round
    always_comb begin
        w_screen_mode = r_mode_q;
        if (r_state == ST_MENU) begin
            w_screen_mode = w_mode;
        end
    end

    // Registered outputs; idle is the complement of the other two so the
    // screen selects can never be anything but one-hot
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            screen_idle   <= 1'b1;
            screen_single <= 1'b0;
            screen_multi  <= 1'b0;
            game_run      <= 1'b0;
            countdown     <= '0;
            round_start   <= 1'b0;
        end else begin
            screen_single <= (w_screen_mode == MODE_SINGLE);
            screen_multi  <= (w_screen_mode == MODE_MULTI);
            screen_idle   <= !((w_screen_mode == MODE_SINGLE) || (w_screen_mode == MODE_MULTI));
            game_run      <= (r_state == ST_PLAY);
            countdown     <= (r_state == ST_COUNTDOWN) ? r_digit : 2'd0;
            round_start   <= r_play_entry;
        end
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer that owns the screen-select outputs and the round lifecycle. It filters the two mode switches over frame ticks and latches the chosen mode. It then steps through a visible countdown, the play phase and a game-over hold before returning to the menu. It sits between the board inputs (switches, start button, frame tick from the VGA timing block) and the screen/draw and game-logic blocks.

## Interface
Parameters:
- SETTLE_FRAMES, default 8: number of frame ticks the switches must stay stable before a mode change is accepted (≥1).
- COUNTDOWN_FRAMES, default 60: frame ticks per countdown digit (≥1).
- END_FRAMES, default 180: frame ticks the game-over screen is held (≥1).

Ports:
- clk65MHz  input  1  pixel clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- sw  input  2  mode switches; sw[0]=single, sw[1]=multi; already synchronised to clk65MHz.
- btn_start  input  1  start button level, already debounced.
- frame_tick  input  1  one-cycle pulse per video frame.
- game_over  input  1  one-cycle pulse from game logic when the round ends.
- screen_idle  output  1  idle/menu-without-mode screen select.
- screen_single  output  1  singleplayer screen select.
- screen_multi  output  1  multiplayer screen select.
- game_run  output  1  high while in PLAY.
- countdown  output  2  digit to display (3,2,1); 0 outside COUNTDOWN.
- round_start  output  1  one-cycle pulse on entry to PLAY.

## Operation
- Switch filter: sw_cand and settle counter. If sw ≠ sw_cand: sw_cand←sw, counter←0. Otherwise, on frame_tick, the counter increments, saturating at SETTLE_FRAMES. When the counter equals SETTLE_FRAMES, sw_stable←sw_cand.
- Mode decode from sw_stable: 00→IDLE, 01→SINGLE, 10→MULTI, 11→IDLE.
- start_edge = btn_start & ~btn_start_d. Holding the button never retriggers.
- FSM states: MENU, COUNTDOWN, PLAY, OVER.
  - MENU: screen outputs follow the decoded mode. On start_edge with decoded mode ≠ IDLE: latch the mode into mode_q, set digit←3, frame counter←0, and go to COUNTDOWN. With decoded mode IDLE, start_edge is ignored.
  - COUNTDOWN: on each frame_tick the counter increments. When the counter reaches COUNTDOWN_FRAMES−1 on a tick, the counter clears and the digit decrements. If the digit was 1, go to PLAY and pulse round_start.
  - PLAY: game_run=1. game_over goes to OVER with counter←0.
  - OVER: count frame_ticks. On the END_FRAMES-th tick, go to MENU.
- Abort: in COUNTDOWN, PLAY or OVER, if decoded sw_stable differs from mode_q, go to MENU next cycle. Abort has priority over game_over, countdown expiry and OVER expiry in the same cycle.
- In COUNTDOWN, PLAY and OVER, the screen outputs show mode_q, one-hot.
- Screen outputs are always exactly one-hot.

## Timing
- All outputs are registered. Each output reflects a state or mode change one cycle after the transition edge.
- Reset values:
  - state MENU, sw_cand=00, sw_stable=00, all counters 0, digit 0.
  - screen_idle=1, screen_single=0, screen_multi=0.
  - game_run=0, countdown=0, round_start=0.
- rst mid-round forces the reset values on the next edge, regardless of inputs.
- Switch latency: a change is accepted on the SETTLE_FRAMES-th frame_tick after the last sw change. The screen output updates one cycle later.
- COUNTDOWN lasts exactly 3·COUNTDOWN_FRAMES frame ticks. game_run rises and round_start pulses on the same cycle.
- round_start is high for exactly one cycle per round.
- game_over outside PLAY is ignored. btn_start outside MENU is ignored, and a press held from before MENU entry does not start a round.

## Test plan
Bench parameters: SETTLE_FRAMES=2, COUNTDOWN_FRAMES=2, END_FRAMES=3.
- Reset, then sw=00 with 5 frame ticks → screen_idle=1, others 0, game_run=0, countdown=0.
- sw=01 bouncing (01→00→01 between ticks), then stable → screen_single=1 only after 2 ticks following the last change. Sw=11 stable → screen_idle=1.
- sw=10 settled, btn_start rise → countdown 3,2,1, each for 2 ticks. Then game_run=1 and round_start is a single 1-cycle pulse, with screen_multi=1 throughout.
- In PLAY, game_over pulse → game_run=0, OVER held for 3 ticks, then back to MENU with screen_multi=1. btn_start held across OVER→MENU does not restart.
- In PLAY, sw changed to 01 and settled, with game_over in the same cycle as the settle → state MENU (not OVER), screen_single=1.
- rst asserted during COUNTDOWN → next cycle all outputs at reset values. btn_start with sw=00 → no state change.
